// File: rtl/nios_dbg_mon_pkg.sv
// nios_dbg_mon_pkg: shared types and jdo field positions for the debug monitor memory
package nios_dbg_mon_pkg;
    typedef enum logic [2:0] {IDLE, JT_RD, JT_RDD, JT_WR, AV_RD, AV_RDD, AV_WR} state_e;
    typedef enum logic [1:0] {OP_NONE, OP_RD, OP_WR} jop_e;
    localparam int JDO_DATA_LSB = 3;
    localparam int JDO_DATA_MSB = 34;
    localparam int JDO_ADDR_LSB = 18;
    localparam int JDO_ADDR_MSB = 25;
    localparam int JDO_RD_BIT   = 34;
    localparam int JDO_CLR_BIT  = 35;
endpackage

// File: rtl/nios_dbg_mon_ram.sv
// nios_dbg_mon_ram: single-port 32-bit RAM with byte enables and 1-cycle synchronous read
// Ports: clk; addr_i word address; we_i write strobe; be_i byte enables;
//        wdata_i write data; rdata_o read data, registered (contents are never reset)
module nios_dbg_mon_ram #(
    parameter int WORDS = 256
) (
    input  logic                     clk,
    input  logic [$clog2(WORDS)-1:0] addr_i,
    input  logic                     we_i,
    input  logic [3:0]               be_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);
    logic [31:0] mem_q [WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (we_i && be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        rdata_o <= mem_q[addr_i];
    end
endmodule

// File: rtl/nios_dbg_mon_mem.sv
// nios_dbg_mon_mem: JTAG debug monitor RAM shared between a JTAG op port and an Avalon slave
// Ports: clk, reset (async, active high); jdo + take_* strobes load the address,
//        queue JTAG reads/writes; av_* is the CPU-side Avalon slave (waitrequest style);
//        MonDReg last JTAG read data, monitor_ready op done, monitor_error sticky overrun.
// MEM_WORDS must be a power of two no larger than 256 (addresses are 8 bits wide).
module nios_dbg_mon_mem
    import nios_dbg_mon_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_no_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic [7:0]  av_address,
    input  logic        av_read,
    input  logic        av_write,
    input  logic [31:0] av_writedata,
    input  logic [3:0]  av_byteenable,
    output logic [31:0] av_readdata,
    output logic        av_waitrequest,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error
);
    localparam int AW = $clog2(MEM_WORDS);

    state_e      state_q, state_d;
    jop_e        pend_q, pend_d, new_op, go_op;
    logic [7:0]  mon_a_q, mon_a_d;
    logic [31:0] mon_d_q, mon_d_d, av_rd_q, av_rd_d, wdata_q, wdata_d;
    logic        ready_q, ready_d, error_q, error_d;
    logic        strobe, busy, accept, done;
    logic [7:0]  ram_addr;
    logic [31:0] ram_rdata;
    logic        unused_jdo;

    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};
    assign strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    // A JTAG op is in flight from acceptance until the cycle that completes it.
    assign busy   = pend_q != OP_NONE || state_q inside {JT_RD, JT_RDD, JT_WR};
    assign accept = strobe && !busy;
    assign done   = state_q inside {JT_RDD, JT_WR};
    assign new_op = !accept ? OP_NONE :
                    take_action_ocimem_a ? (jdo[JDO_RD_BIT] ? OP_RD : OP_NONE) :
                    take_no_action_ocimem_a ? OP_RD : OP_WR;
    // In IDLE an op arriving this cycle starts at once, so it beats a same-cycle Avalon request;
    // ops arriving during an Avalon access wait in the pending slot.
    assign go_op  = pend_q != OP_NONE ? pend_q : new_op;

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = go_op == OP_RD ? JT_RD : go_op == OP_WR ? JT_WR :
                               av_write ? AV_WR : av_read ? AV_RD : IDLE;
            JT_RD:   state_d = JT_RDD;
            AV_RD:   state_d = AV_RDD;
            default: state_d = IDLE;
        endcase
        pend_d  = state_q == IDLE ? OP_NONE : new_op != OP_NONE ? new_op : pend_q;
        mon_a_d = accept && take_action_ocimem_a ? jdo[JDO_ADDR_MSB:JDO_ADDR_LSB] :
                  done ? mon_a_q + 8'd1 : mon_a_q;
        wdata_d = new_op == OP_WR ? jdo[JDO_DATA_MSB:JDO_DATA_LSB] : wdata_q;
        mon_d_d = state_q == JT_RDD ? ram_rdata : mon_d_q;
        av_rd_d = state_q == AV_RD ? ram_rdata : av_rd_q;
        ready_d = new_op != OP_NONE ? 1'b0 : done ? 1'b1 : ready_q;
        error_d = strobe && busy ? 1'b1 :
                  accept && take_action_ocimem_a && jdo[JDO_CLR_BIT] ? 1'b0 : error_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= OP_NONE;
            mon_a_q <= '0;
            mon_d_q <= '0;
            av_rd_q <= '0;
            wdata_q <= '0;
            ready_q <= 1'b1;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            mon_a_q <= mon_a_d;
            mon_d_q <= mon_d_d;
            av_rd_q <= av_rd_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    // Avalon reads are issued from IDLE so the data is ready to register at the end of AV_RD.
    assign ram_addr = state_q inside {JT_RD, JT_WR} ? mon_a_q : av_address;

    nios_dbg_mon_ram #(.WORDS(MEM_WORDS)) u_ram (
        .clk     (clk),
        .addr_i  (ram_addr[AW-1:0]),
        .we_i    (state_q inside {JT_WR, AV_WR}),
        .be_i    (state_q == JT_WR ? 4'hF : av_byteenable),
        .wdata_i (state_q == JT_WR ? wdata_q : av_writedata),
        .rdata_o (ram_rdata)
    );

    assign av_readdata    = av_rd_q;
    assign av_waitrequest = !(state_q inside {AV_RDD, AV_WR});
    assign MonDReg        = mon_d_q;
    assign monitor_ready  = ready_q;
    assign monitor_error  = error_q;
endmodule

// File: tb/tb_nios_dbg_mon_mem.sv
// tb_nios_dbg_mon_mem: randomized self-checking bench against a transaction-level memory model
module tb_nios_dbg_mon_mem;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] jdo = '0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic [7:0]  av_address = '0;
    logic        av_read = 1'b0;
    logic        av_write = 1'b0;
    logic [31:0] av_writedata = '0;
    logic [3:0]  av_byteenable = '0;
    logic [31:0] av_readdata, MonDReg;
    logic        av_waitrequest, monitor_ready, monitor_error;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] mem_m [256];
    logic [7:0]  mon_a_m;

    nios_dbg_mon_mem #(.MEM_WORDS(256)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .av_address              (av_address),
        .av_read                 (av_read),
        .av_write                (av_write),
        .av_writedata            (av_writedata),
        .av_byteenable           (av_byteenable),
        .av_readdata             (av_readdata),
        .av_waitrequest          (av_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        merge = o;
        for (int b = 0; b < 4; b++) if (be[b]) merge[8*b +: 8] = n[8*b +: 8];
    endfunction

    // One-cycle strobe; returns at the negedge after the DUT sampled it.
    task automatic strobe(input int kind, input logic [37:0] j);
        @(negedge clk);
        jdo = j;
        take_action_ocimem_a = kind == 0;
        take_no_action_ocimem_a = kind == 1;
        take_action_ocimem_b = kind == 2;
        @(negedge clk);
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!monitor_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic finish_read(input string tag);
        int n;
        chk({tag, "_rdy_low"}, monitor_ready, 1'b0);
        wait_ready(n);
        chk({tag, "_lat"}, n, 2);
        chk({tag, "_data"}, MonDReg, mem_m[mon_a_m]);
        mon_a_m++;
    endtask

    task automatic jt_addr(input logic [7:0] a, input logic rd, input logic clr);
        logic [37:0] j;
        j = '0;
        j[25:18] = a;
        j[34] = rd;
        j[35] = clr;
        strobe(0, j);
        mon_a_m = a;
        if (rd) finish_read("jaddr_rd");
    endtask

    task automatic jt_read();
        strobe(1, '0);
        finish_read("jrd");
    endtask

    task automatic jt_write(input logic [31:0] d);
        logic [37:0] j;
        int n;
        j = '0;
        j[34:3] = d;
        strobe(2, j);
        wait_ready(n);
        chk("jwr_rdy", monitor_ready, 1'b1);
        mem_m[mon_a_m] = d;
        mon_a_m++;
    endtask

    task automatic av_xfer(input logic rd, input logic wr, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] be, output int n, output logic [31:0] q);
        @(negedge clk);
        av_read = rd;
        av_write = wr;
        av_address = a;
        av_writedata = d;
        av_byteenable = be;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (av_waitrequest && n < 20);
        q = av_readdata;
        @(posedge clk);
        #1;
        av_read = 1'b0;
        av_write = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] q, d;
        logic [7:0] a;
        logic [3:0] be;
        logic [37:0] j;
        repeat (3) @(negedge clk);
        chk("rst_mond", MonDReg, 32'h0);
        chk("rst_avrd", av_readdata, 32'h0);
        chk("rst_rdy", monitor_ready, 1'b1);
        chk("rst_err", monitor_error, 1'b0);
        chk("rst_wait", av_waitrequest, 1'b1);
        reset = 1'b0;
        mon_a_m = 8'h00;
        for (int i = 0; i < 256; i++) begin
            d = $urandom;
            av_xfer(1'b0, 1'b1, i[7:0], d, 4'hF, n, q);
            mem_m[i] = d;
            if (i == 0) chk("avwr_lat", n, 1);
        end
        // address load, JTAG write, post-increment, then Avalon read-back and byte-masked write
        jt_addr(8'h10, 1'b0, 1'b0);
        jt_write(32'hDEADBEEF);
        jt_read();
        av_xfer(1'b1, 1'b0, 8'h10, '0, 4'h0, n, q);
        chk("avrd_lat", n, 2);
        chk("avrd_data", q, 32'hDEADBEEF);
        av_xfer(1'b0, 1'b1, 8'h10, 32'h12345678, 4'b0011, n, q);
        mem_m[8'h10] = merge(mem_m[8'h10], 32'h12345678, 4'b0011);
        av_xfer(1'b1, 1'b0, 8'h10, '0, 4'h0, n, q);
        chk("av_be", q, 32'hDEAD5678);
        // MonAReg wrap 0xFF -> 0x00
        jt_addr(8'hFF, 1'b0, 1'b0);
        jt_read();
        jt_read();
        // JTAG write and Avalon read in the same cycle; second strobe during the op
        jt_addr(8'h20, 1'b0, 1'b0);
        @(negedge clk);
        j = '0;
        j[34:3] = 32'hCAFEF00D;
        jdo = j;
        take_action_ocimem_b = 1'b1;
        av_read = 1'b1;
        av_address = 8'h20;
        n = 0;
        @(negedge clk);
        n++;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b1;
        chk("pri_err_pre", monitor_error, 1'b0);
        @(negedge clk);
        n++;
        take_no_action_ocimem_a = 1'b0;
        while (av_waitrequest && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pri_lat", n, 4);
        chk("pri_data", av_readdata, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        av_read = 1'b0;
        mem_m[8'h20] = 32'hCAFEF00D;
        mon_a_m = 8'h21;
        chk("drop_err", monitor_error, 1'b1);
        jt_read();
        chk("err_sticky", monitor_error, 1'b1);
        jt_addr(8'h30, 1'b0, 1'b1);
        chk("err_clr", monitor_error, 1'b0);
        // strobe held for two cycles: second copy dropped, then reset during JT_WR
        jt_addr(8'h40, 1'b0, 1'b0);
        @(negedge clk);
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        wait_ready(n);
        chk("hold_data", MonDReg, mem_m[8'h40]);
        chk("hold_err", monitor_error, 1'b1);
        @(negedge clk);
        j = '0;
        j[34:3] = 32'h0BADF00D;
        jdo = j;
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_mond", MonDReg, 32'h0);
        chk("mrst_avrd", av_readdata, 32'h0);
        chk("mrst_rdy", monitor_ready, 1'b1);
        chk("mrst_err", monitor_error, 1'b0);
        chk("mrst_wait", av_waitrequest, 1'b1);
        reset = 1'b0;
        mon_a_m = 8'h00;
        av_xfer(1'b1, 1'b0, 8'h41, '0, 4'h0, n, q);
        chk("mrst_nowr", q, mem_m[8'h41]);
        jt_read();
        // randomized mix of JTAG and Avalon traffic
        for (int i = 0; i < 300; i++) begin
            a = 8'($urandom);
            d = $urandom;
            be = 4'($urandom);
            case ($urandom_range(0, 6))
                0: jt_addr(a, 1'($urandom), 1'b0);
                1: jt_read();
                2: jt_write(d);
                3: begin
                    av_xfer(1'b1, 1'b0, a, d, be, n, q);
                    chk("r_avrd_lat", n, 2);
                    chk("r_avrd_data", q, mem_m[a]);
                end
                4, 5: begin
                    av_xfer(1'($urandom), 1'b1, a, d, be, n, q);
                    chk("r_avwr_lat", n, 1);
                    mem_m[a] = merge(mem_m[a], d, be);
                end
                default: begin
                    @(negedge clk);
                    av_read = 1'b1;
                    av_address = a;
                    @(negedge clk);
                    j = '0;
                    j[34:3] = d;
                    jdo = j;
                    take_action_ocimem_b = 1'b1;
                    @(negedge clk);
                    take_action_ocimem_b = 1'b0;
                    chk("slot_rdy_low", monitor_ready, 1'b0);
                    chk("slot_avwait", av_waitrequest, 1'b0);
                    chk("slot_avdata", av_readdata, mem_m[a]);
                    @(posedge clk);
                    #1;
                    av_read = 1'b0;
                    wait_ready(n);
                    chk("slot_rdy", monitor_ready, 1'b1);
                    mem_m[mon_a_m] = d;
                    mon_a_m++;
                end
            endcase
            chk("r_err", monitor_error, 1'b0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
